// File: rtl/dbg_arbiter_if.sv
// Debug port between the arbiter and the core under debug.
// cmd == 0 means idle; the core keeps dut_ready low while cmd is 0.
interface dbg_intf #(parameter int BITSIZE = 32);
  logic [15:0]        cmd;
  logic [BITSIZE-1:0] addr;
  logic [BITSIZE-1:0] data_dbg_dut;
  logic [BITSIZE-1:0] data_dut_dbg;
  logic               dut_ready;

  modport dbg (output cmd, addr, data_dbg_dut, input data_dut_dbg, dut_ready);
  modport dut (input cmd, addr, data_dbg_dut, output data_dut_dbg, dut_ready);
endinterface

// File: rtl/dbg_arbiter.sv
// Round-robin arbiter sharing one debug port between NREQ requesters, one transaction at a time.
// Optional ready timeout in ISSUE is compiled in with `define DBG_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | port idle, pick next requester round-robin after last grant
// ISSUE   | cmd/addr/data held on the port, waiting for dut_ready
// RESP    | response captured, rsp_valid pulse and cmd drop issued on exit
// RELEASE | cmd is 0, waiting for dut_ready to fall before the next grant
module dbg_arbiter #(
  parameter int BITSIZE        = 32,
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [16*NREQ-1:0]      req_cmd_i,
  input  logic [BITSIZE*NREQ-1:0] req_addr_i,
  input  logic [BITSIZE*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic [NREQ-1:0]         rsp_valid_o,
  output logic [BITSIZE-1:0]      rsp_data_o,
  output logic                    rsp_err_o,
  dbg_intf.dbg                    dbg
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_RELEASE} state_t;

  state_t             state, state_n;
  logic [IW-1:0]      rr, rr_n, gnt, gnt_n, pick;
  logic               found;
  logic [15:0]        cmd_n;
  logic [BITSIZE-1:0] addr_n, wdata_n, rdata_n;
  logic               err_n;
  logic [NREQ-1:0]    ready_n, rspv_n;
  logic               timeout;

  if (NREQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("dbg_arbiter: NREQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

`ifdef DBG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt;

  // Held at zero outside ISSUE, so it starts from zero on every entry.
  always_ff @(posedge clk) begin
    if (rst_i || state != S_ISSUE) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

  assign timeout = (state == S_ISSUE) && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // First valid requester strictly after the last grant, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = rr;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req_valid_i[(int'(rr) + i) % NREQ]) begin
        found = 1'b1;
        pick  = IW'((int'(rr) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_n = state;
    rr_n    = rr;
    gnt_n   = gnt;
    cmd_n   = dbg.cmd;
    addr_n  = dbg.addr;
    wdata_n = dbg.data_dbg_dut;
    rdata_n = rsp_data_o;
    err_n   = rsp_err_o;
    ready_n = '0;
    rspv_n  = '0;
    case (state)
      S_IDLE: begin
        if (found) begin
          ready_n[pick] = 1'b1;
          rr_n          = pick;
          gnt_n         = pick;
          if (req_cmd_i[16*pick +: 16] == 16'h0) begin
            // An idle command never reaches the core; answer with an error.
            cmd_n   = 16'h0;
            rdata_n = '0;
            err_n   = 1'b1;
            state_n = S_RESP;
          end else begin
            cmd_n   = req_cmd_i[16*pick +: 16];
            addr_n  = req_addr_i[BITSIZE*pick +: BITSIZE];
            wdata_n = req_data_i[BITSIZE*pick +: BITSIZE];
            state_n = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (dbg.dut_ready) begin
          rdata_n = dbg.data_dut_dbg;
          err_n   = 1'b0;
          state_n = S_RESP;
        end else if (timeout) begin
          rdata_n = '0;
          err_n   = 1'b1;
          state_n = S_RESP;
        end
      end
      S_RESP: begin
        rspv_n[gnt] = 1'b1;
        cmd_n       = 16'h0;
        state_n     = S_RELEASE;
      end
      S_RELEASE: begin
        if (!dbg.dut_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state            <= S_IDLE;
      rr               <= IW'(NREQ - 1);
      gnt              <= '0;
      dbg.cmd          <= '0;
      dbg.addr         <= '0;
      dbg.data_dbg_dut <= '0;
      req_ready_o      <= '0;
      rsp_valid_o      <= '0;
      rsp_data_o       <= '0;
      rsp_err_o        <= 1'b0;
    end else begin
      state            <= state_n;
      rr               <= rr_n;
      gnt              <= gnt_n;
      dbg.cmd          <= cmd_n;
      dbg.addr         <= addr_n;
      dbg.data_dbg_dut <= wdata_n;
      req_ready_o      <= ready_n;
      rsp_valid_o      <= rspv_n;
      rsp_data_o       <= rdata_n;
      rsp_err_o        <= err_n;
    end
  end

endmodule
